ysyx_22041207_mem_arbiter: RTL and testbench
============================================

YSYX_22041207_MEM_ARBITER -- requirements
Module: ysyx_22041207_mem_arbiter

Interface
REQ-001 clk  input  1  single clock; all state updates on posedge clk.
REQ-002 rst_n  input  1  reset, synchronous, active-low.
REQ-003 if_req_valid  input  1  instruction-fetch request pending.
REQ-004 if_req_addr  input  64  fetch address.
REQ-005 if_req_ready  output  1  fetch request accepted this cycle.
REQ-006 if_rsp_valid  output  1  fetch response valid, one-cycle pulse.
REQ-007 if_rsp_data  output  64  fetch response data.
REQ-008 ls_req_valid  input  1  load/store request pending.
REQ-009 ls_req_addr  input  64  load/store address.
REQ-010 ls_req_wen  input  1  1 = store, 0 = load.
REQ-011 ls_req_wdata  input  64  store data.
REQ-012 ls_req_wmask  input  8  store byte mask.
REQ-013 ls_req_ready  output  1  load/store request accepted this cycle.
REQ-014 ls_rsp_valid  output  1  load/store response valid, one-cycle pulse.
REQ-015 ls_rsp_data  output  64  load/store response data.
REQ-016 mem_req_valid  output  1  request to the shared memory port.
REQ-017 mem_req_addr / mem_req_wen / mem_req_wdata / mem_req_wmask  output  64/1/64/8  captured request fields.
REQ-018 mem_req_ready  input  1  memory accepts request.
REQ-019 mem_rsp_valid  input  1  memory response valid.
REQ-020 mem_rsp_data  input  64  memory response data.

Function
REQ-021 FSM states IDLE, REQ, RESP; plus registers owner (IF/LS), last_grant (IF/LS) and captured request fields.
REQ-022 IDLE: exactly one valid requester -> that requester wins; both valid -> the requester not equal to last_grant wins.
REQ-023 Winner's *_req_ready is combinationally high in the same IDLE cycle; loser's ready stays 0; no ready outside IDLE.
REQ-024 On acceptance: capture address/wen/wdata/wmask, set owner and last_grant = winner, next state REQ.
REQ-025 IF capture forces wen=0, wdata=0, wmask=0.
REQ-026 REQ: mem_req_valid=1 with captured fields held stable; on mem_req_ready=1 next state RESP; otherwise stay REQ indefinitely.
REQ-027 mem_req_valid=0 and mem_req_* fields=0 in IDLE and RESP.
REQ-028 RESP: on mem_rsp_valid=1, next cycle owner's *_rsp_valid=1 for exactly one cycle with *_rsp_data=mem_rsp_data (registered), next state IDLE.
REQ-029 Stores also receive a response pulse; data = mem_rsp_data, content unspecified by memory.
REQ-030 *_rsp_data holds its last value until the owner's next response; the non-owner's rsp outputs are unchanged.
REQ-031 mem_req_ready outside REQ and mem_rsp_valid outside RESP are ignored.
REQ-032 Latency: accept at cycle T, mem_req_valid at T+1; with mem_req_ready at T+1 and mem_rsp_valid at T+2, rsp_valid at T+3; IDLE at T+3 may accept a new request in that cycle.
REQ-033 At most one outstanding transaction; new requests wait (ready=0) until IDLE.

Reset
REQ-034 rst_n=0 at a posedge: state=IDLE, owner=IF, last_grant=IF, captured fields=0, all outputs 0, including rsp_data.
REQ-035 Reset mid-transaction (REQ or RESP) drops it: no rsp pulse issued; a late mem_rsp_valid after reset is ignored.
REQ-036 During rst_n=0 all *_req_ready=0.

Verification
REQ-037 Single fetch: if_req_valid, addr 0x80000000, ready, mem_req_ready at T+1, mem_rsp_valid at T+2, data 0x00000413 -> if_req_ready at T, mem_req_addr 0x80000000 at T+1, if_rsp_valid=1 at T+3, if_rsp_data=0x00000413.
REQ-038 Simultaneous IF and LS valid after reset -> LS wins first (last_grant=IF); the next tie -> IF wins; alternation continues.
REQ-039 Store LS addr 0x80001000, wdata 0xDEADBEEF, wmask 0x0F, mem_req_ready low 5 cycles -> mem_req_* stable all 6 cycles, single ls_rsp_valid pulse after response.
REQ-040 mem_rsp_valid asserted in IDLE and REQ -> no rsp pulse, state unchanged.
REQ-041 rst_n=0 while in RESP, then mem_rsp_valid -> no rsp pulse, IDLE, all outputs 0.

Source files
------------

// File: rtl/ysyx_22041207_mem_arbiter.sv
// rtl/ysyx_22041207_mem_arbiter.sv - two-requester (fetch, load/store) arbiter onto one memory port
// Alternating priority on ties; one transaction in flight at a time.
module ysyx_22041207_mem_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req_valid,
  input  logic [63:0] if_req_addr,
  output logic        if_req_ready,
  output logic        if_rsp_valid,
  output logic [63:0] if_rsp_data,
  input  logic        ls_req_valid,
  input  logic [63:0] ls_req_addr,
  input  logic        ls_req_wen,
  input  logic [63:0] ls_req_wdata,
  input  logic [7:0]  ls_req_wmask,
  output logic        ls_req_ready,
  output logic        ls_rsp_valid,
  output logic [63:0] ls_rsp_data,
  output logic        mem_req_valid,
  output logic [63:0] mem_req_addr,
  output logic        mem_req_wen,
  output logic [63:0] mem_req_wdata,
  output logic [7:0]  mem_req_wmask,
  input  logic        mem_req_ready,
  input  logic        mem_rsp_valid,
  input  logic [63:0] mem_rsp_data
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]  state;
  logic        owner_ls;
  logic        last_ls;
  logic [63:0] cap_addr;
  logic        cap_wen;
  logic [63:0] cap_wdata;
  logic [7:0]  cap_wmask;

  logic in_idle;
  logic in_req;
  logic grant_if;
  logic grant_ls;

  // On a tie the requester that did not win last time is served.
  always_comb begin
    in_idle  = rst_n && (state == S_IDLE);
    in_req   = (state == S_REQ);
    grant_ls = in_idle && ls_req_valid && (!if_req_valid || !last_ls);
    grant_if = in_idle && if_req_valid && (!ls_req_valid || last_ls);
  end

  assign if_req_ready  = grant_if;
  assign ls_req_ready  = grant_ls;
  assign mem_req_valid = in_req;
  assign mem_req_addr  = in_req ? cap_addr  : 64'd0;
  assign mem_req_wen   = in_req ? cap_wen   : 1'b0;
  assign mem_req_wdata = in_req ? cap_wdata : 64'd0;
  assign mem_req_wmask = in_req ? cap_wmask : 8'd0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      owner_ls     <= 1'b0;
      last_ls      <= 1'b0;
      cap_addr     <= 64'd0;
      cap_wen      <= 1'b0;
      cap_wdata    <= 64'd0;
      cap_wmask    <= 8'd0;
      if_rsp_valid <= 1'b0;
      if_rsp_data  <= 64'd0;
      ls_rsp_valid <= 1'b0;
      ls_rsp_data  <= 64'd0;
    end else begin
      if_rsp_valid <= 1'b0;
      ls_rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_ls) begin
            cap_addr  <= ls_req_addr;
            cap_wen   <= ls_req_wen;
            cap_wdata <= ls_req_wdata;
            cap_wmask <= ls_req_wmask;
            owner_ls  <= 1'b1;
            last_ls   <= 1'b1;
            state     <= S_REQ;
          end else if (grant_if) begin
            cap_addr  <= if_req_addr;
            cap_wen   <= 1'b0;
            cap_wdata <= 64'd0;
            cap_wmask <= 8'd0;
            owner_ls  <= 1'b0;
            last_ls   <= 1'b0;
            state     <= S_REQ;
          end
        end
        S_REQ: begin
          if (mem_req_ready) state <= S_RESP;
        end
        S_RESP: begin
          if (mem_rsp_valid) begin
            if (owner_ls) begin
              ls_rsp_valid <= 1'b1;
              ls_rsp_data  <= mem_rsp_data;
            end else begin
              if_rsp_valid <= 1'b1;
              if_rsp_data  <= mem_rsp_data;
            end
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22041207_mem_arbiter.sv
// tb/tb_ysyx_22041207_mem_arbiter.sv - vector table, store-stall sequence and randomized model check
module tb_ysyx_22041207_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req_valid = 1'b0;
  logic [63:0] if_req_addr = 64'd0;
  logic        if_req_ready;
  logic        if_rsp_valid;
  logic [63:0] if_rsp_data;
  logic        ls_req_valid = 1'b0;
  logic [63:0] ls_req_addr = 64'd0;
  logic        ls_req_wen = 1'b0;
  logic [63:0] ls_req_wdata = 64'd0;
  logic [7:0]  ls_req_wmask = 8'd0;
  logic        ls_req_ready;
  logic        ls_rsp_valid;
  logic [63:0] ls_rsp_data;
  logic        mem_req_valid;
  logic [63:0] mem_req_addr;
  logic        mem_req_wen;
  logic [63:0] mem_req_wdata;
  logic [7:0]  mem_req_wmask;
  logic        mem_req_ready = 1'b0;
  logic        mem_rsp_valid = 1'b0;
  logic [63:0] mem_rsp_data = 64'd0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ysyx_22041207_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .ls_req_valid(ls_req_valid), .ls_req_addr(ls_req_addr), .ls_req_wen(ls_req_wen),
    .ls_req_wdata(ls_req_wdata), .ls_req_wmask(ls_req_wmask), .ls_req_ready(ls_req_ready),
    .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
    .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask), .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit rst, ifv, lsv, mrdy, mrsp;
    logic [63:0] rdata;
    bit e_ifr, e_lsr, e_mv;
    logic [63:0] e_maddr;
    bit e_ifrv, e_lsrv;
    logic [63:0] e_ifd, e_lsd;
  } vec_t;

  localparam logic [63:0] A_IF = 64'h8000_0000;
  localparam logic [63:0] A_LS = 64'h8000_1000;

  vec_t tbl[23];

  // Transaction-level reference for the random phase.
  typedef struct {
    bit          busy;
    bit          sent;
    bit          to_ls;
    logic [63:0] addr;
    bit          wen;
    logic [63:0] wdata;
    logic [7:0]  wmask;
  } txn_t;

  txn_t        cur;
  bit          m_last_ls;
  bit          m_pulse_if, m_pulse_ls;
  logic [63:0] m_d_if, m_d_ls;

  initial begin
    int pulses;
    bit e_ifr, e_lsr, e_mv;

    tbl[0]  = '{0,0,0,0,0,64'h0,    0,0,0,64'h0, 0,0,64'h0,64'h0};
    tbl[1]  = '{1,1,0,0,0,64'h0,    1,0,0,64'h0, 0,0,64'h0,64'h0};
    tbl[2]  = '{1,0,0,1,0,64'h0,    0,0,1,A_IF,  0,0,64'h0,64'h0};
    tbl[3]  = '{1,0,0,0,1,64'h413,  0,0,0,64'h0, 0,0,64'h0,64'h0};
    tbl[4]  = '{1,0,0,0,0,64'h0,    0,0,0,64'h0, 1,0,64'h413,64'h0};
    tbl[5]  = '{1,1,1,0,0,64'h0,    0,1,0,64'h0, 0,0,64'h413,64'h0};
    tbl[6]  = '{1,1,1,0,1,64'h9999, 0,0,1,A_LS,  0,0,64'h413,64'h0};
    tbl[7]  = '{1,1,1,1,0,64'h0,    0,0,1,A_LS,  0,0,64'h413,64'h0};
    tbl[8]  = '{1,1,1,0,1,64'h1111, 0,0,0,64'h0, 0,0,64'h413,64'h0};
    tbl[9]  = '{1,1,1,0,0,64'h0,    1,0,0,64'h0, 0,1,64'h413,64'h1111};
    tbl[10] = '{1,1,1,1,0,64'h0,    0,0,1,A_IF,  0,0,64'h413,64'h1111};
    tbl[11] = '{1,0,0,0,1,64'h2222, 0,0,0,64'h0, 0,0,64'h413,64'h1111};
    tbl[12] = '{1,1,1,0,0,64'h0,    0,1,0,64'h0, 1,0,64'h2222,64'h1111};
    tbl[13] = '{1,0,0,1,0,64'h0,    0,0,1,A_LS,  0,0,64'h2222,64'h1111};
    tbl[14] = '{0,0,0,0,1,64'h3333, 0,0,0,64'h0, 0,0,64'h2222,64'h1111};
    tbl[15] = '{1,0,0,0,1,64'h4444, 0,0,0,64'h0, 0,0,64'h0,64'h0};
    tbl[16] = '{1,0,0,0,0,64'h0,    0,0,0,64'h0, 0,0,64'h0,64'h0};
    tbl[17] = '{1,0,0,0,1,64'h5555, 0,0,0,64'h0, 0,0,64'h0,64'h0};
    tbl[18] = '{1,0,0,0,0,64'h0,    0,0,0,64'h0, 0,0,64'h0,64'h0};
    tbl[19] = '{1,1,1,0,0,64'h0,    0,1,0,64'h0, 0,0,64'h0,64'h0};
    tbl[20] = '{0,1,1,1,0,64'h0,    0,0,1,A_LS,  0,0,64'h0,64'h0};
    tbl[21] = '{0,1,0,0,0,64'h0,    0,0,0,64'h0, 0,0,64'h0,64'h0};
    tbl[22] = '{1,0,0,0,0,64'h0,    0,0,0,64'h0, 0,0,64'h0,64'h0};

    repeat (2) next_cycle();

    if_req_addr  = A_IF;
    ls_req_addr  = A_LS;
    ls_req_wen   = 1'b1;
    ls_req_wdata = 64'hDEAD_BEEF;
    ls_req_wmask = 8'h0F;
    for (int i = 0; i < 23; i++) begin
      next_cycle();
      rst_n         = tbl[i].rst;
      if_req_valid  = tbl[i].ifv;
      ls_req_valid  = tbl[i].lsv;
      mem_req_ready = tbl[i].mrdy;
      mem_rsp_valid = tbl[i].mrsp;
      mem_rsp_data  = tbl[i].rdata;
      @(negedge clk);
      chk($sformatf("v%0d_if_req_ready", i),  {63'd0, if_req_ready},  {63'd0, tbl[i].e_ifr});
      chk($sformatf("v%0d_ls_req_ready", i),  {63'd0, ls_req_ready},  {63'd0, tbl[i].e_lsr});
      chk($sformatf("v%0d_mem_req_valid", i), {63'd0, mem_req_valid}, {63'd0, tbl[i].e_mv});
      chk($sformatf("v%0d_mem_req_addr", i),  mem_req_addr, tbl[i].e_maddr);
      chk($sformatf("v%0d_if_rsp_valid", i),  {63'd0, if_rsp_valid},  {63'd0, tbl[i].e_ifrv});
      chk($sformatf("v%0d_ls_rsp_valid", i),  {63'd0, ls_rsp_valid},  {63'd0, tbl[i].e_lsrv});
      chk($sformatf("v%0d_if_rsp_data", i),   if_rsp_data, tbl[i].e_ifd);
      chk($sformatf("v%0d_ls_rsp_data", i),   ls_rsp_data, tbl[i].e_lsd);
    end

    // Store held off by memory for five cycles.
    next_cycle();
    rst_n = 1'b0; if_req_valid = 1'b0; ls_req_valid = 1'b0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    next_cycle();
    rst_n = 1'b1; ls_req_valid = 1'b1;
    @(negedge clk);
    chk("st_ls_req_ready", {63'd0, ls_req_ready}, 64'd1);
    for (int c = 0; c < 6; c++) begin
      next_cycle();
      ls_req_valid  = 1'b0;
      mem_req_ready = (c == 5);
      @(negedge clk);
      chk($sformatf("st%0d_mem_req_valid", c), {63'd0, mem_req_valid}, 64'd1);
      chk($sformatf("st%0d_mem_req_addr", c), mem_req_addr, A_LS);
      chk($sformatf("st%0d_mem_req_wen", c), {63'd0, mem_req_wen}, 64'd1);
      chk($sformatf("st%0d_mem_req_wdata", c), mem_req_wdata, 64'hDEAD_BEEF);
      chk($sformatf("st%0d_mem_req_wmask", c), {56'd0, mem_req_wmask}, 64'h0F);
    end
    next_cycle();
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 64'hABCD;
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (ls_rsp_valid) begin
        pulses++;
        chk("st_ls_rsp_data", ls_rsp_data, 64'hABCD);
      end
      next_cycle();
      mem_rsp_valid = 1'b0;
    end
    chk("st_ls_rsp_pulses", 64'(pulses), 64'd1);
    chk("st_if_rsp_data_kept", if_rsp_data, 64'd0);

    // Randomized traffic against the transaction model.
    cur = '{0,0,0,64'h0,0,64'h0,8'h0};
    m_last_ls = 0; m_pulse_if = 0; m_pulse_ls = 0; m_d_if = 0; m_d_ls = 0;
    for (int i = 0; i < 3000; i++) begin
      next_cycle();
      rst_n         = (i == 0) ? 1'b0 : ($urandom_range(0, 59) != 0);
      if_req_valid  = $urandom_range(0, 1);
      if_req_addr   = {$urandom, $urandom};
      ls_req_valid  = $urandom_range(0, 1);
      ls_req_addr   = {$urandom, $urandom};
      ls_req_wen    = $urandom_range(0, 1);
      ls_req_wdata  = {$urandom, $urandom};
      ls_req_wmask  = 8'($urandom);
      mem_req_ready = $urandom_range(0, 2) == 0;
      mem_rsp_valid = $urandom_range(0, 2) == 0;
      mem_rsp_data  = {$urandom, $urandom};
      @(negedge clk);
      if (i == 0) continue;

      e_ifr = 0; e_lsr = 0;
      if (rst_n && !cur.busy) begin
        if (if_req_valid && ls_req_valid) begin
          e_lsr = !m_last_ls;
          e_ifr = m_last_ls;
        end else begin
          e_ifr = if_req_valid;
          e_lsr = ls_req_valid;
        end
      end
      e_mv = cur.busy && !cur.sent;
      chk("r_if_req_ready", {63'd0, if_req_ready}, {63'd0, e_ifr});
      chk("r_ls_req_ready", {63'd0, ls_req_ready}, {63'd0, e_lsr});
      chk("r_mem_req_valid", {63'd0, mem_req_valid}, {63'd0, e_mv});
      chk("r_mem_req_addr", mem_req_addr, e_mv ? cur.addr : 64'd0);
      chk("r_mem_req_wen", {63'd0, mem_req_wen}, {63'd0, e_mv && cur.wen});
      chk("r_mem_req_wdata", mem_req_wdata, e_mv ? cur.wdata : 64'd0);
      chk("r_mem_req_wmask", {56'd0, mem_req_wmask}, {56'd0, e_mv ? cur.wmask : 8'd0});
      chk("r_if_rsp_valid", {63'd0, if_rsp_valid}, {63'd0, m_pulse_if});
      chk("r_ls_rsp_valid", {63'd0, ls_rsp_valid}, {63'd0, m_pulse_ls});
      chk("r_if_rsp_data", if_rsp_data, m_d_if);
      chk("r_ls_rsp_data", ls_rsp_data, m_d_ls);

      m_pulse_if = 0; m_pulse_ls = 0;
      if (!rst_n) begin
        cur = '{0,0,0,64'h0,0,64'h0,8'h0};
        m_last_ls = 0; m_d_if = 0; m_d_ls = 0;
      end else if (cur.busy && cur.sent) begin
        if (mem_rsp_valid) begin
          if (cur.to_ls) begin m_pulse_ls = 1; m_d_ls = mem_rsp_data; end
          else begin m_pulse_if = 1; m_d_if = mem_rsp_data; end
          cur.busy = 0;
        end
      end else if (cur.busy) begin
        if (mem_req_ready) cur.sent = 1;
      end else if (e_lsr) begin
        cur = '{1, 0, 1, ls_req_addr, ls_req_wen, ls_req_wdata, ls_req_wmask};
        m_last_ls = 1;
      end else if (e_ifr) begin
        cur = '{1, 0, 0, if_req_addr, 0, 64'h0, 8'h0};
        m_last_ls = 0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
